cpu_clock_ctrl: RTL and testbench
=================================

CPU_CLOCK_CTRL -- requirements
Module: cpu_clock_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of the half-period divider.
REQ-002 SHALL have parameter DEFAULT_HALF, default 1: the reset value of the active divider. Half-period = divider+1 fpga_clk cycles.
REQ-003 SHALL have port fpga_clk, input, 1 bit: the single clock. All flops clock on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port half_div, input, DIV_W bits: requested divider value.
REQ-006 SHALL have port div_load, input, 1 bit: one-cycle pulse that captures half_div as the pending divider.
REQ-007 SHALL have port run, input, 1 bit: level input that enables free-running phi2.
REQ-008 SHALL have port step_req, input, 1 bit: one-cycle pulse requesting exactly one phi2 cycle while halted.
REQ-009 SHALL have port step_ack, output, 1 bit: one-cycle pulse when the stepped cycle completes.
REQ-010 SHALL have port phi2, output, 1 bit: generated CPU clock, registered.
REQ-011 SHALL have ports phi2_rise and phi2_fall, output, 1 bit each: one-cycle pulses, asserted in the same cycle phi2 becomes 1 or 0 respectively.
REQ-012 SHALL have port halted, output, 1 bit: high in IDLE, when phi2 is stopped low.
REQ-013 SHALL have port cycle_count, output, 32 bits: count of completed phi2 cycles.

Function
REQ-014 SHALL implement the states IDLE, LOW, HIGH, plus a step_mode flag.
- phi2 = 1 only in HIGH.
REQ-015 SHALL leave IDLE as follows:
- run=1 → LOW, cnt=0, step_mode=0.
- else step_req=1 → LOW, cnt=0, step_mode=1.
- else stay in IDLE.
- run has priority over step_req.
REQ-016 SHALL, in LOW and HIGH, increment cnt each cycle. When cnt==active_div: cnt←0 and the phase toggles.
- LOW→HIGH asserts phi2_rise.
REQ-017 SHALL treat the end of HIGH as the cycle boundary. At the boundary:
- phi2←0, phi2_fall=1.
- cycle_count +1, wrapping from 2^32-1 to 0.
- Next state IDLE if step_mode=1 (step_ack=1 the same cycle) or run=0; else LOW.
REQ-018 SHALL never truncate or glitch a phase: deasserting run mid-cycle completes the current cycle, then enters IDLE.
REQ-019 SHALL apply the divider as follows:
- div_load latches half_div into pending and sets a pending flag.
- active_div←pending only at a cycle boundary or while in IDLE, then the flag clears.
- div_load coincident with a boundary applies the new half_div at that boundary.
- A later div_load before application overwrites pending.
REQ-020 SHALL, with active_div=0, produce phi2 = fpga_clk/2 (1-cycle phases).
- With active_div=2^DIV_W-1, phases are 2^DIV_W cycles.
REQ-021 SHALL ignore step_req outside IDLE: no ack and no queuing.
REQ-022 SHALL assert first phi2_rise (active_div+1) cycles after the edge that enters LOW.
- Steady-state period = 2·(active_div+1) cycles, 50% duty.
REQ-023 SHALL keep step_ack, phi2_rise and phi2_fall high for exactly one cycle per event.

Reset
REQ-024 SHALL, on reset=1 and without waiting for a clock edge, set:
- state=IDLE, phi2=0, halted=1.
- step_ack=0, phi2_rise=0, phi2_fall=0.
- cnt=0, cycle_count=0.
- active_div=DEFAULT_HALF; pending flag cleared.
REQ-025 SHALL, when reset asserts mid-operation, abort the cycle with no phi2_fall pulse and no cycle_count increment. Normal operation resumes from IDLE on the first edge after release.

Verification
REQ-026 SHALL cover free run at the default divider:
- Stimulus: reset release, run=1, DEFAULT_HALF=1.
- Response: phi2 period 4 cycles (2 high/2 low); first rise 2 cycles after entering LOW; cycle_count=10 after 10 falls.
REQ-027 SHALL cover single step:
- Stimulus: run=0, one step_req pulse.
- Response: exactly one rise and one fall; step_ack coincident with phi2_fall; cycle_count +1; halted back to 1.
- A second step_req during the step produces no extra cycle.
REQ-028 SHALL cover a divider change mid-cycle:
- Stimulus: half_div=3 with div_load while in HIGH at divider 1.
- Response: current cycle finishes 2/2; the following cycles are 4 high/4 low (period 8).
REQ-029 SHALL cover run dropping mid-cycle:
- Stimulus: run drops 1 cycle into LOW.
- Response: full HIGH phase still occurs; halted rises at the boundary; phi2 stays 0 afterwards.
REQ-030 SHALL cover asynchronous reset mid-cycle:
- Stimulus: reset pulsed mid-HIGH, between fpga_clk edges.
- Response: phi2=0 and halted=1 immediately; no phi2_fall; cycle_count=0.
REQ-031 SHALL cover minimum divider and run priority:
- Stimulus: half_div=0 loaded in IDLE, then step_req and run asserted together.
- Response: phi2 toggles every cycle; step_mode=0; no step_ack.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl
//   Generates the CPU clock phi2 from fpga_clk. phi2 is free-running while
//   run is high, or produces a single cycle on a step_req pulse while halted.
//   Each phi2 phase lasts active_div+1 fpga_clk cycles. A new divider is
//   staged with div_load and only takes effect at a cycle boundary (end of
//   HIGH) or while idle, so a phase is never shortened or stretched.
//
// Ports
//   fpga_clk     in   system clock, all flops on rising edge
//   reset        in   asynchronous active-high reset
//   half_div     in   requested divider (half-period = half_div+1 cycles)
//   div_load     in   one-cycle pulse capturing half_div as pending divider
//   run          in   level, enables free-running phi2
//   step_req     in   one-cycle pulse, one phi2 cycle while halted
//   step_ack     out  one-cycle pulse when the stepped cycle completes
//   phi2         out  generated CPU clock (registered)
//   phi2_rise    out  one-cycle pulse in the cycle phi2 becomes 1
//   phi2_fall    out  one-cycle pulse in the cycle phi2 becomes 0
//   halted       out  high while idle (phi2 stopped low)
//   cycle_count  out  completed phi2 cycles, wraps at 2^32

module cpu_clock_ctrl #(
    parameter int DIV_W        = 8,
    parameter int DEFAULT_HALF = 1
) (
    input  logic             fpga_clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] half_div,
    input  logic             div_load,
    input  logic             run,
    input  logic             step_req,
    output logic             step_ack,
    output logic             phi2,
    output logic             phi2_rise,
    output logic             phi2_fall,
    output logic             halted,
    output logic [31:0]      cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] CNT_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(DEFAULT_HALF);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [DIV_W-1:0] active_div, active_div_nxt;
    logic [DIV_W-1:0] pending_div, pending_div_nxt;
    logic             pending_vld, pending_vld_nxt;
    logic             step_mode, step_mode_nxt;
    logic             phi2_nxt, rise_nxt, fall_nxt, ack_nxt;
    logic [31:0]      cycle_count_nxt;
    logic             phase_end;
    logic             boundary;
    logic             div_apply;

    assign phase_end = (cnt == active_div);
    // End of HIGH closes a phi2 cycle; this is the only place besides IDLE
    // where the divider may change without distorting a phase.
    assign boundary  = (state == HIGH) && phase_end;
    assign div_apply = boundary || (state == IDLE);
    assign halted    = (state == IDLE);

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        step_mode_nxt   = step_mode;
        phi2_nxt        = phi2;
        rise_nxt        = 1'b0;
        fall_nxt        = 1'b0;
        ack_nxt         = 1'b0;
        cycle_count_nxt = cycle_count;

        unique case (state)
            IDLE: begin
                phi2_nxt = 1'b0;
                // run wins over step_req when both are present
                if (run) begin
                    state_nxt     = LOW;
                    cnt_nxt       = '0;
                    step_mode_nxt = 1'b0;
                end else if (step_req) begin
                    state_nxt     = LOW;
                    cnt_nxt       = '0;
                    step_mode_nxt = 1'b1;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    phi2_nxt  = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    cnt_nxt         = '0;
                    phi2_nxt        = 1'b0;
                    fall_nxt        = 1'b1;
                    cycle_count_nxt = cycle_count + 32'd1;
                    if (step_mode) begin
                        ack_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (!run) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = LOW;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                phi2_nxt  = 1'b0;
            end
        endcase
    end

    // A load arriving on the apply edge bypasses the pending register so the
    // newest request wins; otherwise a staged value is promoted.
    always_comb begin
        active_div_nxt  = active_div;
        pending_div_nxt = pending_div;
        pending_vld_nxt = pending_vld;

        if (div_apply) begin
            if (div_load) begin
                active_div_nxt = half_div;
            end else if (pending_vld) begin
                active_div_nxt = pending_div;
            end
            pending_vld_nxt = 1'b0;
        end else if (div_load) begin
            pending_div_nxt = half_div;
            pending_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            step_mode   <= 1'b0;
            phi2        <= 1'b0;
            phi2_rise   <= 1'b0;
            phi2_fall   <= 1'b0;
            step_ack    <= 1'b0;
            cycle_count <= 32'd0;
            active_div  <= DIV_RESET;
            pending_div <= '0;
            pending_vld <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            step_mode   <= step_mode_nxt;
            phi2        <= phi2_nxt;
            phi2_rise   <= rise_nxt;
            phi2_fall   <= fall_nxt;
            step_ack    <= ack_nxt;
            cycle_count <= cycle_count_nxt;
            active_div  <= active_div_nxt;
            pending_div <= pending_div_nxt;
            pending_vld <= pending_vld_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl
//   Self-checking bench for cpu_clock_ctrl. Each scenario task pushes the
//   phi2_rise / phi2_fall / step_ack events it expects (kind + fpga_clk edge
//   number) into a scoreboard queue; a monitor pops and compares whenever
//   the DUT emits a pulse. Levels (phi2, halted, cycle_count) are compared
//   inline by the tasks.

module tb_cpu_clock_ctrl;

    localparam int DIV_W        = 8;
    localparam int DEFAULT_HALF = 1;

    localparam logic [1:0] EV_RISE = 2'd0;
    localparam logic [1:0] EV_FALL = 2'd1;
    localparam logic [1:0] EV_ACK  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] cyc;
    } ev_t;

    logic             fpga_clk = 1'b0;
    logic             reset    = 1'b1;
    logic [DIV_W-1:0] half_div = '0;
    logic             div_load = 1'b0;
    logic             run      = 1'b0;
    logic             step_req = 1'b0;
    logic             step_ack;
    logic             phi2;
    logic             phi2_rise;
    logic             phi2_fall;
    logic             halted;
    logic [31:0]      cycle_count;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc      = 32'd0;
    ev_t         exp_q[$];

    cpu_clock_ctrl #(
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) dut (
        .fpga_clk    (fpga_clk),
        .reset       (reset),
        .half_div    (half_div),
        .div_load    (div_load),
        .run         (run),
        .step_req    (step_req),
        .step_ack    (step_ack),
        .phi2        (phi2),
        .phi2_rise   (phi2_rise),
        .phi2_fall   (phi2_fall),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    always #5 fpga_clk = ~fpga_clk;

    // cyc holds the number of the most recent rising edge
    always @(posedge fpga_clk) cyc <= cyc + 32'd1;

    always @(negedge fpga_clk) begin : monitor
        logic [2:0] seen;
        ev_t        e;
        seen = {step_ack, phi2_fall, phi2_rise};
        for (int k = 0; k < 3; k++) begin
            if (seen[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_event unexpected kind=%0d at cyc=%0d, required no event", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== 2'(k) || e.cyc !== cyc) begin
                        failures++;
                        $display("FAIL sb_event got kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                                 k, cyc, e.kind, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push_ev(input logic [1:0] kind, input logic [31:0] c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge fpga_clk);
        checks++; if (phi2 !== 1'b0) begin failures++; $display("FAIL reset_phi2 got %b required 0", phi2); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL reset_halted got %b required 1", halted); end
        checks++; if (step_ack !== 1'b0) begin failures++; $display("FAIL reset_step_ack got %b required 0", step_ack); end
        checks++; if (phi2_rise !== 1'b0) begin failures++; $display("FAIL reset_rise got %b required 0", phi2_rise); end
        checks++; if (phi2_fall !== 1'b0) begin failures++; $display("FAIL reset_fall got %b required 0", phi2_fall); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_cycle_count got %0d required 0", cycle_count); end
        reset = 1'b0;
        repeat (3) @(negedge fpga_clk);
        checks++; if (halted !== 1'b1 || phi2 !== 1'b0) begin
            failures++; $display("FAIL reset_idle_hold got halted=%b phi2=%b required halted=1 phi2=0", halted, phi2);
        end
    endtask

    // divider 1: period 4, first rise 2 edges after entering LOW
    task automatic test_free_run();
        logic [31:0] t0;
        logic        exp_phi2;
        t0 = cyc + 32'd1;
        for (int n = 0; n < 10; n++) begin
            push_ev(EV_RISE, t0 + 32'((2*n+1)*2));
            push_ev(EV_FALL, t0 + 32'((2*n+2)*2));
        end
        run = 1'b1;
        for (int k = 0; k < 44; k++) begin
            @(negedge fpga_clk);
            exp_phi2 = (k < 40) && ((k % 4) >= 2);
            checks++; if (phi2 !== exp_phi2) begin
                failures++; $display("FAIL free_run_phi2 k=%0d got %b required %b", k, phi2, exp_phi2);
            end
            if (k == 38) run = 1'b0;
            if (k == 40) begin
                checks++; if (cycle_count !== 32'd10) begin
                    failures++; $display("FAIL free_run_count got %0d required 10", cycle_count);
                end
                checks++; if (halted !== 1'b1) begin
                    failures++; $display("FAIL free_run_halted got %b required 1", halted);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL free_run_events_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic test_single_step();
        logic [31:0] t0;
        logic        exp_phi2;
        logic        exp_halt;
        t0 = cyc + 32'd1;
        push_ev(EV_RISE, t0 + 32'd2);
        push_ev(EV_FALL, t0 + 32'd4);
        push_ev(EV_ACK,  t0 + 32'd4);
        step_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge fpga_clk);
            exp_phi2 = (k == 2) || (k == 3);
            exp_halt = (k >= 4);
            checks++; if (phi2 !== exp_phi2) begin
                failures++; $display("FAIL step_phi2 k=%0d got %b required %b", k, phi2, exp_phi2);
            end
            checks++; if (halted !== exp_halt) begin
                failures++; $display("FAIL step_halted k=%0d got %b required %b", k, halted, exp_halt);
            end
            if (k == 4) begin
                checks++; if (cycle_count !== 32'd11) begin
                    failures++; $display("FAIL step_count got %0d required 11", cycle_count);
                end
            end
            if (k == 0) step_req = 1'b0;
            if (k == 2) step_req = 1'b1;
            if (k == 3) step_req = 1'b0;
        end
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL step_events_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    // loads 5 then 3 before the boundary; 3 must win, current cycle stays 2/2
    task automatic test_div_change();
        logic [31:0] t0;
        logic        exp_phi2;
        t0 = cyc + 32'd1;
        push_ev(EV_RISE, t0 + 32'd2);
        push_ev(EV_FALL, t0 + 32'd4);
        for (int n = 0; n < 3; n++) begin
            push_ev(EV_RISE, t0 + 32'd4 + 32'(4*(2*n+1)));
            push_ev(EV_FALL, t0 + 32'd4 + 32'(4*(2*n+2)));
        end
        run = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge fpga_clk);
            if (k < 4) exp_phi2 = (k >= 2);
            else       exp_phi2 = (k < 28) && (((k - 4) % 8) >= 4);
            checks++; if (phi2 !== exp_phi2) begin
                failures++; $display("FAIL div_change_phi2 k=%0d got %b required %b", k, phi2, exp_phi2);
            end
            if (k == 1) begin half_div = 8'd5; div_load = 1'b1; end
            if (k == 2) begin half_div = 8'd3; div_load = 1'b1; end
            if (k == 3) div_load = 1'b0;
            if (k == 25) run = 1'b0;
            if (k == 28) begin
                checks++; if (cycle_count !== 32'd15) begin
                    failures++; $display("FAIL div_change_count got %0d required 15", cycle_count);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL div_change_events_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    // divider 3: run drops right after entering LOW, full cycle still runs
    task automatic test_run_drop();
        logic [31:0] t0;
        logic        exp_phi2;
        logic        exp_halt;
        t0 = cyc + 32'd1;
        push_ev(EV_RISE, t0 + 32'd4);
        push_ev(EV_FALL, t0 + 32'd8);
        run = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge fpga_clk);
            if (k == 0) run = 1'b0;
            exp_phi2 = (k >= 4) && (k < 8);
            exp_halt = (k >= 8);
            checks++; if (phi2 !== exp_phi2) begin
                failures++; $display("FAIL run_drop_phi2 k=%0d got %b required %b", k, phi2, exp_phi2);
            end
            checks++; if (halted !== exp_halt) begin
                failures++; $display("FAIL run_drop_halted k=%0d got %b required %b", k, halted, exp_halt);
            end
            if (k == 8) begin
                checks++; if (cycle_count !== 32'd16) begin
                    failures++; $display("FAIL run_drop_count got %0d required 16", cycle_count);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL run_drop_events_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    // divider 3: reset pulse in the middle of HIGH, between clock edges
    task automatic test_async_reset();
        logic [31:0] t0;
        t0 = cyc + 32'd1;
        push_ev(EV_RISE, t0 + 32'd4);
        run = 1'b1;
        repeat (6) @(negedge fpga_clk);
        checks++; if (phi2 !== 1'b1) begin
            failures++; $display("FAIL async_pre_phi2 got %b required 1", phi2);
        end
        #1;
        reset = 1'b1;
        run   = 1'b0;
        #1;
        checks++; if (phi2 !== 1'b0) begin failures++; $display("FAIL async_phi2 got %b required 0", phi2); end
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL async_halted got %b required 1", halted); end
        checks++; if (phi2_fall !== 1'b0) begin failures++; $display("FAIL async_fall got %b required 0", phi2_fall); end
        checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL async_count got %0d required 0", cycle_count); end
        #1;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge fpga_clk);
            checks++; if (phi2 !== 1'b0 || halted !== 1'b1 || cycle_count !== 32'd0) begin
                failures++;
                $display("FAIL async_after k=%0d got phi2=%b halted=%b count=%0d required 0 1 0",
                         k, phi2, halted, cycle_count);
            end
        end
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL async_events_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    // divider 0 loaded in IDLE; run and step_req together, run must win
    task automatic test_min_div_priority();
        logic [31:0] t0;
        logic        exp_phi2;
        half_div = 8'd0;
        div_load = 1'b1;
        @(negedge fpga_clk);
        div_load = 1'b0;
        @(negedge fpga_clk);
        t0 = cyc + 32'd1;
        for (int n = 0; n < 6; n++) begin
            push_ev(EV_RISE, t0 + 32'(2*n+1));
            push_ev(EV_FALL, t0 + 32'(2*n+2));
        end
        run      = 1'b1;
        step_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge fpga_clk);
            if (k == 0) step_req = 1'b0;
            exp_phi2 = (k < 12) && ((k % 2) == 1);
            checks++; if (phi2 !== exp_phi2) begin
                failures++; $display("FAIL min_div_phi2 k=%0d got %b required %b", k, phi2, exp_phi2);
            end
            if (k == 11) run = 1'b0;
            if (k == 12) begin
                checks++; if (cycle_count !== 32'd6 || halted !== 1'b1) begin
                    failures++;
                    $display("FAIL min_div_end got count=%0d halted=%b required 6 1", cycle_count, halted);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL min_div_events_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    // load coincident with a boundary while running, to the maximum divider
    task automatic test_div_boundary();
        logic [31:0] t0;
        logic        exp_phi2;
        t0 = cyc + 32'd1;
        push_ev(EV_RISE, t0 + 32'd1);
        push_ev(EV_FALL, t0 + 32'd2);
        push_ev(EV_RISE, t0 + 32'd258);
        push_ev(EV_FALL, t0 + 32'd514);
        run = 1'b1;
        for (int k = 0; k < 518; k++) begin
            @(negedge fpga_clk);
            exp_phi2 = (k == 1) || ((k >= 258) && (k < 514));
            checks++; if (phi2 !== exp_phi2) begin
                failures++; $display("FAIL div_boundary_phi2 k=%0d got %b required %b", k, phi2, exp_phi2);
            end
            if (k == 1) begin half_div = 8'd255; div_load = 1'b1; end
            if (k == 2) div_load = 1'b0;
            if (k == 300) run = 1'b0;
            if (k == 100) begin
                checks++; if (halted !== 1'b0) begin
                    failures++; $display("FAIL div_boundary_running got halted=%b required 0", halted);
                end
            end
            if (k == 514) begin
                checks++; if (cycle_count !== 32'd8 || halted !== 1'b1) begin
                    failures++;
                    $display("FAIL div_boundary_end got count=%0d halted=%b required 8 1", cycle_count, halted);
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin
            failures++; $display("FAIL div_boundary_events_missing got %0d pending required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_single_step();
        test_div_change();
        test_run_drop();
        test_async_reset();
        test_min_div_priority();
        test_div_boundary();
        repeat (2) @(negedge fpga_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
